// File: rtl/banner_rotator.sv
// banner_rotator: loads a message of 4-bit character codes, scrolls an
// 8-character window through it at a prescaled rate, and generates the
// digit-scan index plus the active-low anode vector for the display.
module banner_rotator #(
   parameter int         MSG_MAX     = 16,
   parameter int         SHIFT_DIV   = 50_000_000,
   parameter int         REFRESH_DIV = 100_000,
   parameter logic [3:0] BLANK       = 4'hF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_valid,
   input  logic [3:0] load_data,
   input  logic       load_last,
   output logic       load_ready,
   input  logic       clear,
   input  logic       run_en,
   input  logic       dir,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic [3:0] digit4,
   output logic [3:0] digit5,
   output logic [3:0] digit6,
   output logic [3:0] digit7,
   output logic [3:0] refreshCounter,
   output logic [7:0] anode
);

   // Index arithmetic carries one extra bit so msg_len == MSG_MAX is representable.
   localparam int IW = $clog2(MSG_MAX) + 1;
   localparam int SW = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [IW-1:0] LAST_SLOT  = IW'(MSG_MAX - 1);
   localparam logic [SW-1:0] SHIFT_TC   = SW'(SHIFT_DIV - 1);
   localparam logic [RW-1:0] REFRESH_TC = RW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, HOLD} state_t;

   state_t        state_reg, state_next;
   logic [3:0]    msg [MSG_MAX];
   logic [IW-1:0] wr_ptr_reg, msg_len_reg, offset_reg, offset_step;
   logic [SW-1:0] shift_cnt_reg;
   logic [RW-1:0] refresh_cnt_reg;
   logic [2:0]    scan_reg, scan_next;
   logic [7:0]    anode_reg;
   logic          accept, load_end, scrolling;

   // Loads are only taken while collecting a message; clear blocks any beat.
   assign load_ready = ((state_reg == IDLE) || (state_reg == LOAD)) && !clear;
   assign accept     = load_valid && load_ready;
   // The beat that fills the last slot ends the message even without load_last.
   assign load_end   = load_last || (wr_ptr_reg == LAST_SLOT);
   assign scrolling  = (state_reg == RUN) && run_en;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state logic; clear overrides every other transition.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, LOAD: if (accept) state_next = load_end ? RUN : LOAD;
         RUN:        if (!run_en) state_next = HOLD;
         HOLD:       if (run_en) state_next = RUN;
         default:    state_next = IDLE;
      endcase
      if (clear) state_next = IDLE;
   end

   // Next scroll offset, wrapping len-1 <-> 0 by comparison instead of division.
   always_comb begin
      offset_step = offset_reg;
      if (dir) offset_step = (offset_reg == '0) ? msg_len_reg - 1'b1 : offset_reg - 1'b1;
      else     offset_step = (offset_reg + 1'b1 == msg_len_reg) ? '0 : offset_reg + 1'b1;
   end

   // Message storage; contents are don't-care until msg_len becomes non-zero.
   always_ff @(posedge clk) begin
      if (accept) msg[wr_ptr_reg[IW-2:0]] <= load_data;
   end

   // Write pointer, message length, offset and shift prescaler.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg    <= '0;
         msg_len_reg   <= '0;
         offset_reg    <= '0;
         shift_cnt_reg <= '0;
      end else if (clear) begin
         wr_ptr_reg    <= '0;
         msg_len_reg   <= '0;
         offset_reg    <= '0;
         shift_cnt_reg <= '0;
      end else if (accept) begin
         wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (load_end) begin
            msg_len_reg   <= wr_ptr_reg + 1'b1;
            offset_reg    <= '0;
            shift_cnt_reg <= '0;
         end
      end else if (scrolling) begin
         if (shift_cnt_reg == SHIFT_TC) begin
            shift_cnt_reg <= '0;
            offset_reg    <= offset_step;
         end else begin
            shift_cnt_reg <= shift_cnt_reg + 1'b1;
         end
      end
   end

   // Window: each digit position is the previous one plus one, wrapped at msg_len,
   // so short messages repeat across the eight digits.
   for (genvar gi = 0; gi < 8; gi++) begin : g_win
      logic [IW-1:0] pos;
      logic [3:0]    shown;
      if (gi == 0) begin : g_first
         assign pos = offset_reg;
      end else begin : g_next
         logic [IW-1:0] inc;
         assign inc = g_win[gi-1].pos + 1'b1;
         assign pos = (inc == msg_len_reg) ? '0 : inc;
      end

      // Registered digit: blank while no message is loaded or on clear.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                           shown <= BLANK;
         else if (clear || msg_len_reg == '0)  shown <= BLANK;
         else if (pos[IW-1])                   shown <= BLANK;
         else                                  shown <= msg[pos[IW-2:0]];
      end
   end

   assign digit0 = g_win[0].shown;
   assign digit1 = g_win[1].shown;
   assign digit2 = g_win[2].shown;
   assign digit3 = g_win[3].shown;
   assign digit4 = g_win[4].shown;
   assign digit5 = g_win[5].shown;
   assign digit6 = g_win[6].shown;
   assign digit7 = g_win[7].shown;

   assign scan_next = scan_reg + 3'd1;

   // Free-running scan: refresh prescaler, digit index and matching anode vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         refresh_cnt_reg <= '0;
         scan_reg        <= '0;
         anode_reg       <= 8'hFE;
      end else if (refresh_cnt_reg == REFRESH_TC) begin
         refresh_cnt_reg <= '0;
         scan_reg        <= scan_next;
         anode_reg       <= ~(8'd1 << scan_next);
      end else begin
         refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
      end
   end

   assign refreshCounter = {1'b0, scan_reg};
   assign anode          = anode_reg;

endmodule

// File: tb/tb_banner_rotator.sv
// Randomized bench for banner_rotator: a queue-based reference model predicts
// the window and scan outputs each cycle; a monitor pops and compares.
module tb_banner_rotator;
   localparam int MSG_MAX     = 16;
   localparam int SHIFT_DIV   = 8;
   localparam int REFRESH_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_valid = 1'b0;
   logic [3:0] load_data = 4'h0;
   logic       load_last = 1'b0;
   logic       clear = 1'b0;
   logic       run_en = 1'b0;
   logic       dir = 1'b0;
   logic       load_ready;
   logic [3:0] digit0, digit1, digit2, digit3, digit4, digit5, digit6, digit7;
   logic [3:0] refreshCounter;
   logic [7:0] anode;

   banner_rotator #(
      .MSG_MAX(MSG_MAX), .SHIFT_DIV(SHIFT_DIV), .REFRESH_DIV(REFRESH_DIV), .BLANK(4'hF)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready), .clear(clear), .run_en(run_en), .dir(dir),
      .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
      .digit4(digit4), .digit5(digit5), .digit6(digit6), .digit7(digit7),
      .refreshCounter(refreshCounter), .anode(anode)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] win;
      logic [2:0]  scan;
   } exp_t;

   exp_t       exp_q[$];
   int         tests = 0;
   int         fails = 0;

   // Reference model: message as a queue, window by modulo arithmetic.
   int         m_mode = 0;     // 0 collecting-empty, 1 collecting, 2 scrolling, 3 frozen
   logic [3:0] m_msg[$];
   int         m_len = 0;
   int         m_off = 0;
   int         m_presc = 0;
   int         m_cyc = 0;
   logic [3:0] pat [MSG_MAX];

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic logic [31:0] model_window();
      logic [31:0] w;
      w = 32'hFFFF_FFFF;
      if (m_len != 0)
         for (int k = 0; k < 8; k++) w[k*4 +: 4] = m_msg[(m_off + k) % m_len];
      return w;
   endfunction

   // Model step: registered outputs after each edge, pushed to the scoreboard.
   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      if (!rst_n) begin
         m_mode = 0; m_msg.delete(); m_len = 0; m_off = 0; m_presc = 0; m_cyc = 0;
         e.win = 32'hFFFF_FFFF;
         e.scan = 3'd0;
         exp_q.delete();
         exp_q.push_back(e);
      end else begin
         e.win = clear ? 32'hFFFF_FFFF : model_window();
         if (clear) begin
            m_mode = 0; m_msg.delete(); m_len = 0; m_off = 0; m_presc = 0;
         end else begin
            case (m_mode)
               0, 1: if (load_valid) begin
                  m_msg.push_back(load_data);
                  if (load_last || m_msg.size() == MSG_MAX) begin
                     m_len = m_msg.size(); m_off = 0; m_presc = 0; m_mode = 2;
                  end else begin
                     m_mode = 1;
                  end
               end
               2: if (!run_en) m_mode = 3;
                  else begin
                     m_presc++;
                     if (m_presc == SHIFT_DIV) begin
                        m_presc = 0;
                        m_off = dir ? (m_off + m_len - 1) % m_len : (m_off + 1) % m_len;
                     end
                  end
               default: if (run_en) m_mode = 2;
            endcase
         end
         m_cyc++;
         e.scan = 3'((m_cyc / REFRESH_DIV) % 8);
         exp_q.push_back(e);
      end
   end

   // Monitor: compare DUT outputs against the oldest prediction, away from the edge.
   always @(negedge clk) begin
      exp_t        e;
      logic [7:0]  an;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         an = ~(8'd1 << e.scan);
         check("window", {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0}, e.win);
         check("refreshCounter", {28'd0, refreshCounter}, {29'd0, e.scan});
         check("anode", {24'd0, anode}, {24'd0, an});
      end
      check("load_ready", {31'd0, load_ready}, {31'd0, (m_mode <= 1) && !clear});
   end

   task automatic send_msg(input int n, input bit use_last, input bit extra);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         load_valid = 1'b1;
         load_data  = pat[i];
         load_last  = use_last && (i == n - 1);
      end
      if (extra) begin
         @(negedge clk);
         load_data = 4'h5;
         load_last = 1'b0;
      end
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
      $display("[TB] load %0d chars last=%0b extra=%0b dir=%0b", n, use_last, extra, dir);
   endtask

   task automatic pulse_clear();
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      $display("[TB] clear");
   endtask

   task automatic rand_pat();
      for (int i = 0; i < MSG_MAX; i++) pat[i] = 4'($urandom_range(0, 15));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      $display("[TB] reset released, idling");
      repeat (40) @(negedge clk);

      // Ten characters 1..A scrolling left, long enough to wrap.
      run_en = 1'b1; dir = 1'b0;
      for (int i = 0; i < 10; i++) pat[i] = 4'(i + 1);
      send_msg(10, 1'b1, 1'b0);
      repeat (100) @(negedge clk);

      // Three characters scrolling right: window repeats modulo 3.
      pulse_clear();
      pat[0] = 4'hA; pat[1] = 4'hB; pat[2] = 4'hC; dir = 1'b1;
      send_msg(3, 1'b1, 1'b0);
      repeat (30) @(negedge clk);

      // Full buffer without load_last, then a beat that must be refused.
      pulse_clear();
      rand_pat(); dir = 1'b0;
      send_msg(16, 1'b0, 1'b1);
      repeat (21) @(negedge clk);

      // Freeze for 20 cycles, then resume from the held prescaler value.
      run_en = 1'b0;
      $display("[TB] freeze");
      repeat (20) @(negedge clk);
      run_en = 1'b1;
      $display("[TB] resume");
      repeat (30) @(negedge clk);

      // Clear together with a load beat while collecting.
      pulse_clear();
      rand_pat();
      send_msg(2, 1'b0, 1'b0);
      @(negedge clk); load_valid = 1'b1; load_data = 4'h7; clear = 1'b1;
      @(negedge clk); load_valid = 1'b0; clear = 1'b0;
      $display("[TB] clear with load beat");
      repeat (5) @(negedge clk);

      // Random messages with random run_en / dir activity.
      for (int t = 0; t < 12; t++) begin
         int n;
         pulse_clear();
         rand_pat();
         n = $urandom_range(1, MSG_MAX);
         dir = 1'($urandom_range(0, 1));
         send_msg(n, 1'b1, 1'b0);
         for (int c = $urandom_range(5, 60); c > 0; c--) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) run_en = ~run_en;
            if ($urandom_range(0, 15) == 0) dir = ~dir;
         end
         run_en = 1'b1;
      end

      // Asynchronous reset in the middle of scrolling.
      pulse_clear();
      rand_pat();
      send_msg(12, 1'b1, 1'b0);
      repeat (13) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      $display("[TB] async reset mid-run");
      check("rst_window", {digit7, digit6, digit5, digit4, digit3, digit2, digit1, digit0}, 32'hFFFF_FFFF);
      check("rst_anode", {24'd0, anode}, 32'h0000_00FE);
      check("rst_refreshCounter", {28'd0, refreshCounter}, 32'd0);
      check("rst_load_ready", {31'd0, load_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
